// File: rtl/n25q_pkg.sv
// Shared opcodes, state encoding and status-register layout for the N25Q SPI flash responder.
// Optional build macro: N25Q_TARGET_FAST_READ_EN adds the FAST_READ (0x0B) dummy-cycle state.
package n25q_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_WRDI      = 8'h04;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_RDID      = 8'h9F;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_STATUS,
    ST_ID,
    ST_IGNORE
`ifdef N25Q_TARGET_FAST_READ_EN
    , ST_DUMMY
`endif
  } state_e;

  // WEL update requested by WREN/WRDI, applied only when csb rises on the byte boundary.
  typedef enum logic [1:0] {
    WEL_KEEP,
    WEL_SET,
    WEL_CLR
  } wel_op_e;

  function automatic logic [7:0] status_byte(input logic wip, input logic wel);
    logic [7:0] sr;
    sr         = 8'h00;
    sr[SR_WIP] = wip;
    sr[SR_WEL] = wel;
    return sr;
  endfunction

  function automatic logic drives_miso(input state_e s);
    return (s == ST_RD_DATA) || (s == ST_STATUS) || (s == ST_ID);
  endfunction

endpackage

// File: rtl/n25q_spi_sync_edge.sv
// Two-flop synchronizer for one SPI pin plus single-cycle rise/fall pulses in the ifclk domain.
module n25q_spi_sync_edge (
  input  logic ifclk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Resetting every stage to 0 means a csb held low through reset never
  // produces a fall, so the host must deselect and reselect to start a command.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/n25q_spi_target.sv
// N25Q SPI flash responder: oversamples host pins in ifclk and serves a byte-wide memory port.
// Optional build macro: N25Q_TARGET_FAST_READ_EN enables FAST_READ (0x0B) with 8 dummy clocks.
module n25q_spi_target
  import n25q_pkg::*;
#(
  parameter int          ADDR_W    = 24,
  parameter logic [23:0] JEDEC_ID  = 24'h20BA18,
  parameter int          PAGE_LOG2 = 8
) (
  input  logic              ifclk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              csb,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic              mem_busy
);

  localparam logic [2:0] ADDR_LAST = 3'(ADDR_W / 8 - 1);

  logic sclk_rise, sclk_fall, csb_rise, csb_fall;

  n25q_spi_sync_edge u_sclk_sync (
    .ifclk (ifclk),
    .reset (reset),
    .din   (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  n25q_spi_sync_edge u_csb_sync (
    .ifclk (ifclk),
    .reset (reset),
    .din   (csb),
    .rise  (csb_rise),
    .fall  (csb_fall)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        addr_byte_q, addr_byte_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        next_q, next_d;
  logic [23:0]       id_q, id_d;
  logic [ADDR_W-2:0] addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              is_prog_q, is_prog_d;
`ifdef N25Q_TARGET_FAST_READ_EN
  logic              is_fast_q, is_fast_d;
`endif
  logic              wel_q, wel_d;
  wel_op_e           wel_op_q, wel_op_d;
  logic              pp_seen_q, pp_seen_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              mosi_meta_q, mosi_meta_d;
  logic              mosi_sync_q, mosi_sync_d;

  logic [7:0] rx_byte;
  logic [7:0] src_byte;
  logic       byte_done;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_byte_d = addr_byte_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    id_d        = id_q;
    addr_sh_d   = addr_sh_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    is_prog_d   = is_prog_q;
`ifdef N25Q_TARGET_FAST_READ_EN
    is_fast_d   = is_fast_q;
`endif
    wel_d       = wel_q;
    wel_op_d    = wel_op_q;
    pp_seen_d   = pp_seen_q;
    rd_valid_d  = mem_re_q;
    next_d      = rd_valid_q ? mem_rdata : next_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    miso_d      = miso_q;
    mosi_meta_d = mosi;
    mosi_sync_d = mosi_meta_q;
    rx_byte     = {rx_q, mosi_sync_q};
    byte_done   = sclk_rise && (bit_cnt_q == 3'd7);
    src_byte    = 8'h00;

    if (csb_rise) begin
      // Deselect beats any same-cycle sclk edge; partial bytes and prefetches are dropped.
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      if (wel_op_q == WEL_SET) wel_d = 1'b1;
      else if (wel_op_q == WEL_CLR) wel_d = 1'b0;
      if (pp_seen_q) wel_d = 1'b0;
      wel_op_d  = WEL_KEEP;
      pp_seen_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (csb_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end

      case (state_q)
        ST_CMD: if (byte_done) begin
          addr_byte_d = 3'd0;
          is_prog_d   = 1'b0;
`ifdef N25Q_TARGET_FAST_READ_EN
          is_fast_d   = 1'b0;
`endif
          case (rx_byte)
            OP_READ: state_d = ST_ADDR;
            OP_PP: begin
              pp_seen_d = 1'b1;
              if (wel_q && !mem_busy) begin
                state_d   = ST_ADDR;
                is_prog_d = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
            OP_WREN: begin
              state_d  = ST_IGNORE;
              wel_op_d = WEL_SET;
            end
            OP_WRDI: begin
              state_d  = ST_IGNORE;
              wel_op_d = WEL_CLR;
            end
            OP_RDSR: state_d = ST_STATUS;
            OP_RDID: begin
              state_d = ST_ID;
              id_d    = JEDEC_ID;
            end
`ifdef N25Q_TARGET_FAST_READ_EN
            OP_FAST_READ: begin
              state_d   = ST_ADDR;
              is_fast_d = 1'b1;
            end
`endif
            default: state_d = ST_IGNORE;
          endcase
        end

        ST_ADDR: if (sclk_rise) begin
          addr_sh_d = {addr_sh_q[ADDR_W-3:0], mosi_sync_q};
          if (bit_cnt_q == 3'd7) begin
            if (addr_byte_q == ADDR_LAST) begin
              mem_addr_d = {addr_sh_q, mosi_sync_q};
              if (is_prog_q) begin
                state_d = ST_WR_DATA;
              end else begin
                mem_re_d = 1'b1;
                state_d  = ST_RD_DATA;
`ifdef N25Q_TARGET_FAST_READ_EN
                if (is_fast_q) state_d = ST_DUMMY;
`endif
              end
            end else begin
              addr_byte_d = addr_byte_q + 3'd1;
            end
          end
        end

        ST_WR_DATA: begin
          // Advance only after the strobe so the write sees the address it belongs to.
          if (mem_we_q)
            mem_addr_d = {mem_addr_q[ADDR_W-1:PAGE_LOG2],
                          mem_addr_q[PAGE_LOG2-1:0] + PAGE_LOG2'(1)};
          if (byte_done) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = rx_byte;
          end
        end

        ST_IGNORE: if (sclk_rise) wel_op_d = WEL_KEEP;

`ifdef N25Q_TARGET_FAST_READ_EN
        ST_DUMMY: if (byte_done) state_d = ST_RD_DATA;
`endif

        default: ;
      endcase

      if (sclk_fall && drives_miso(state_q)) begin
        if (bit_cnt_q == 3'd0) begin
          case (state_q)
            ST_STATUS: src_byte = status_byte(mem_busy, wel_q);
            ST_ID: begin
              src_byte = id_q[23:16];
              id_d     = {id_q[15:0], 8'h00};
            end
            default: begin
              // The first byte may land in this very cycle, so bypass the buffer.
              src_byte   = rd_valid_q ? mem_rdata : next_q;
              mem_addr_d = mem_addr_q + ADDR_W'(1);
              mem_re_d   = 1'b1;
            end
          endcase
          miso_d = src_byte[7];
          tx_d   = {src_byte[6:0], 1'b0};
        end else begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
    end

    miso_oe_d = drives_miso(state_d);
    if (!miso_oe_d) miso_d = 1'b0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      addr_byte_q <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'h00;
      next_q      <= 8'h00;
      id_q        <= 24'h0;
      addr_sh_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      is_prog_q   <= 1'b0;
`ifdef N25Q_TARGET_FAST_READ_EN
      is_fast_q   <= 1'b0;
`endif
      wel_q       <= 1'b0;
      wel_op_q    <= WEL_KEEP;
      pp_seen_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_byte_q <= addr_byte_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      next_q      <= next_d;
      id_q        <= id_d;
      addr_sh_q   <= addr_sh_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      is_prog_q   <= is_prog_d;
`ifdef N25Q_TARGET_FAST_READ_EN
      is_fast_q   <= is_fast_d;
`endif
      wel_q       <= wel_d;
      wel_op_q    <= wel_op_d;
      pp_seen_q   <= pp_seen_d;
      rd_valid_q  <= rd_valid_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule
